mic_beeper: RTL and testbench

- Parametrised successor to the microphone/buzzer block in the pet-state sensor path.
- Input conditioning: synchronises and debounces the raw microphone line.
- On a clean sound event, or an explicit play request, emits a wake pulse to the main pet FSM and plays a state-dependent beep pattern on the active-low buzzer.
- New over the previous generation:
  - exact beep counting instead of a time window
  - pattern latched at trigger
  - mute
  - cooldown / retrigger lockout
  - busy/done status

---
 rtl/mic_beeper_pkg.sv | 39 +++
 rtl/mic_beeper_debounce.sv | 52 +++++
 rtl/mic_beeper.sv | 161 ++++++++++++++++
 tb/tb_mic_beeper.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mic_beeper_pkg.sv
// Shared types for the microphone/buzzer path: FSM encoding and the
// pet-state to beep-pattern lookup.
package mic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ON       = 2'd1,
    ST_OFF      = 2'd2,
    ST_COOLDOWN = 2'd3
  } beeper_state_e;

  localparam int DIV_MAX = 7;

  typedef struct packed {
    logic [2:0] beeps;
    logic [2:0] div;
  } pattern_t;

  // upper_nz flags any pet-state bit above bit 2, which maps to the default pattern
  function automatic pattern_t pattern_lookup(input logic [2:0] st, input logic upper_nz);
    pattern_t p;
    p.beeps = 3'd1;
    p.div   = 3'd1;
    if (upper_nz) begin
      p.beeps = 3'd1;
      p.div   = 3'd1;
    end else begin
      case (st)
        3'd0, 3'd1: begin p.beeps = 3'd3; p.div = 3'd2; end
        3'd2:       begin p.beeps = 3'd1; p.div = 3'd1; end
        3'd4:       begin p.beeps = 3'd2; p.div = 3'd5; end
        3'd5:       begin p.beeps = 3'd2; p.div = 3'd1; end
        default:    begin p.beeps = 3'd1; p.div = 3'd1; end
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/mic_beeper_debounce.sv
// Two-flop synchroniser and stable-count debouncer for the raw mic line,
// with a registered rising-edge pulse of the debounced level.
module mic_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [DW-1:0] cnt_r;
  logic          level_r;
  logic          rise_r;

  // Synchronise, then accept a new level only after an unbroken run of disagreement
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= {DW{1'b0}};
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (sync2_r != level_r) begin
        if (cnt_r == LAST) begin
          level_r <= sync2_r;
          cnt_r   <= {DW{1'b0}};
          rise_r  <= sync2_r;
        end else begin
          cnt_r   <= cnt_r + DW'(1'b1);
          rise_r  <= 1'b0;
        end
      end else begin
        cnt_r  <= {DW{1'b0}};
        rise_r <= 1'b0;
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/mic_beeper.sv
// Mic/play-request triggered beeper: wakes the pet FSM on a clean sound event
// and plays a pattern, latched at trigger, on the active-low buzzer.
module mic_beeper
  import mic_pkg::*;
#(
  parameter int COUNT_MAX       = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COOLDOWN_UNITS  = 2,
  parameter int STATE_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mic,
  input  logic               play_req,
  input  logic               mute,
  input  logic [STATE_W-1:0] state_t,
  output logic               buzzer,
  output logic               signal_awake,
  output logic               busy,
  output logic               done
);

  localparam int CD_CYCLES = COOLDOWN_UNITS * COUNT_MAX;
  localparam int MAX_CYC   = (CD_CYCLES > COUNT_MAX) ? CD_CYCLES : COUNT_MAX;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);
  localparam bit HAS_CD    = (COOLDOWN_UNITS != 0);

  localparam logic [CNT_W-1:0] PH1     = CNT_W'(COUNT_MAX / 1);
  localparam logic [CNT_W-1:0] PH2     = CNT_W'(COUNT_MAX / 2);
  localparam logic [CNT_W-1:0] PH3     = CNT_W'(COUNT_MAX / 3);
  localparam logic [CNT_W-1:0] PH4     = CNT_W'(COUNT_MAX / 4);
  localparam logic [CNT_W-1:0] PH5     = CNT_W'(COUNT_MAX / 5);
  localparam logic [CNT_W-1:0] PH6     = CNT_W'(COUNT_MAX / 6);
  localparam logic [CNT_W-1:0] PH7     = CNT_W'(COUNT_MAX / DIV_MAX);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(CD_CYCLES - 1);

  beeper_state_e    state_r;
  beeper_state_e    state_n;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] phase_r;
  logic [2:0]       beeps_r;
  logic             buzzer_r;
  logic             awake_r;
  logic             busy_r;
  logic             done_r;

  logic             mic_level_s;
  logic             mic_rise_s;
  logic             mic_edge_s;
  logic             trigger_s;
  pattern_t         pat_s;
  logic [CNT_W-1:0] phase_len_s;
  logic             phase_done_s;
  logic             cd_done_s;
  logic             buzzer_s;
  logic             awake_s;
  logic             busy_s;
  logic             done_s;

  mic_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (mic),
    .level(mic_level_s),
    .rise (mic_rise_s)
  );

  assign mic_edge_s   = mic_rise_s & mic_level_s;
  assign trigger_s    = mic_edge_s | play_req;
  assign pat_s        = pattern_lookup(3'(state_t), |(state_t >> 3'd3));
  assign phase_done_s = (cnt_r == (phase_r - CNT_W'(1'b1)));
  assign cd_done_s    = (cnt_r == CD_LAST);

  // Phase length from precomputed constants, keyed by the pattern divisor
  always_comb begin
    phase_len_s = PH1;
    case (pat_s.div)
      3'd1:    phase_len_s = PH1;
      3'd2:    phase_len_s = PH2;
      3'd3:    phase_len_s = PH3;
      3'd4:    phase_len_s = PH4;
      3'd5:    phase_len_s = PH5;
      3'd6:    phase_len_s = PH6;
      3'd7:    phase_len_s = PH7;
      default: phase_len_s = PH1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trigger_s) state_n = ST_ON;
        else           state_n = ST_IDLE;
      end
      ST_ON: begin
        if (!phase_done_s)        state_n = ST_ON;
        else if (beeps_r > 3'd1)  state_n = ST_OFF;
        else if (HAS_CD)          state_n = ST_COOLDOWN;
        else                      state_n = ST_IDLE;
      end
      ST_OFF: begin
        if (phase_done_s) state_n = ST_ON;
        else              state_n = ST_OFF;
      end
      ST_COOLDOWN: begin
        if (cd_done_s) state_n = ST_IDLE;
        else           state_n = ST_COOLDOWN;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the upcoming state
  always_comb begin
    buzzer_s = mute || (state_n != ST_ON);
    busy_s   = (state_n != ST_IDLE);
    done_s   = (state_r != ST_IDLE) && (state_n == ST_IDLE);
    awake_s  = (state_r == ST_IDLE) && mic_edge_s;
  end

  // State, counters, latched pattern and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      phase_r  <= {CNT_W{1'b0}};
      beeps_r  <= 3'd0;
      buzzer_r <= 1'b1;
      awake_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      if ((state_n != state_r) || (state_r == ST_IDLE)) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
      if ((state_r == ST_IDLE) && trigger_s) begin
        beeps_r <= pat_s.beeps;
        phase_r <= phase_len_s;
      end else if ((state_r == ST_ON) && phase_done_s) begin
        beeps_r <= beeps_r - 3'd1;
      end
      buzzer_r <= buzzer_s;
      awake_r  <= awake_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign buzzer       = buzzer_r;
  assign signal_awake = awake_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_mic_beeper.sv
// Directed bench for mic_beeper: per-cycle expectations are queued when a
// trigger is driven and popped/compared on every falling edge.
module tb_mic_beeper;

  localparam int CM = 20;
  localparam int DB = 4;
  localparam int CU = 1;
  localparam int CD = CU * CM;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mic = 1'b0;
  logic       play_req = 1'b0;
  logic       mute = 1'b0;
  logic [3:0] state_t = 4'd0;
  logic       buzzer;
  logic       signal_awake;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic bz;
    logic by;
    logic dn;
    logic aw;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_tick = 0;

  always #5 clk = ~clk;

  mic_beeper #(
    .COUNT_MAX(CM),
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_UNITS(CU),
    .STATE_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mic(mic),
    .play_req(play_req),
    .mute(mute),
    .state_t(state_t),
    .buzzer(buzzer),
    .signal_awake(signal_awake),
    .busy(busy),
    .done(done)
  );

  task automatic cmp(input string tag, input logic obs, input logic want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s at tick %0d: observed %b expected %b", tag, n_tick, obs, want);
    end
  endtask

  task automatic check_front();
    exp_t e;
    e = exp_q.pop_front();
    cmp("buzzer", buzzer, e.bz);
    cmp("busy", busy, e.by);
    cmp("done", done, e.dn);
    cmp("signal_awake", signal_awake, e.aw);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    n_tick++;
    if (exp_q.size() != 0) check_front();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    while (exp_q.size() != 0) tick();
  endtask

  task automatic push(input logic bz, input logic by, input logic dn, input logic aw, input int n);
    exp_t e;
    e.bz = bz; e.by = by; e.dn = dn; e.aw = aw;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Expected outputs from the cycle after the trigger edge through one idle cycle after done
  task automatic push_pattern(input int nb, input int len, input logic aw, input logic muted);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < len; c++)
        push(muted, 1'b1, 1'b0, (b == 0 && c == 0) ? aw : 1'b0, 1);
      if (b < nb - 1) push(1'b1, 1'b1, 1'b0, 1'b0, len);
    end
    push(1'b1, 1'b1, 1'b0, 1'b0, CD);
    push(1'b1, 1'b0, 1'b1, 1'b0, 1);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic play(input logic [3:0] st, input int nb, input int len, input logic muted);
    state_t  = st;
    play_req = 1'b1;
    push_pattern(nb, len, 1'b0, muted);
    tick();
    play_req = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  found;

    // Reset values
    push(1'b1, 1'b0, 1'b0, 1'b0, 2);
    tick_n(2);
    rst = 1'b1;

    // Short mic glitches must neither wake nor beep
    push(1'b1, 1'b0, 1'b0, 1'b0, 16);
    for (int k = 0; k < 2; k++) begin
      mic = 1'b1;
      tick_n(3);
      mic = 1'b0;
      tick_n(3);
    end
    drain();

    // Held mic with state 0: one wake pulse then 3 beeps of 10 cycles
    state_t = 4'd0;
    mic     = 1'b1;
    lat     = 0;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      lat++;
      if (signal_awake === 1'b1) found = 1'b1;
    end
    n_vec++;
    assert (found && lat >= 6 && lat <= 8) else begin
      n_err++;
      $error("FAIL awake_latency: observed found=%0d after %0d cycles expected 7 (+/-1)", found, lat);
    end
    if (found) begin
      push_pattern(3, CM / 2, 1'b1, 1'b0);
      check_front();
    end
    tick_n(3);
    mic = 1'b0;
    drain();

    // Pattern latched at trigger: state 4 -> 2 mid-pattern keeps 2 beeps of 4
    play(4'd4, 2, CM / 5, 1'b0);
    tick_n(2);
    state_t = 4'd2;
    drain();

    // play_req during OFF and COOLDOWN is dropped
    play(4'd0, 3, CM / 2, 1'b0);
    tick_n(12);
    play_req = 1'b1;
    tick();
    play_req = 1'b0;
    tick_n(40);
    play_req = 1'b1;
    tick();
    play_req = 1'b0;
    drain();

    // Default pattern for state 7, no wake pulse on play_req
    play(4'd7, 1, CM, 1'b0);
    drain();

    // Muted state-5 run: silent buzzer, unchanged timing
    mute = 1'b1;
    play(4'd5, 2, CM, 1'b1);
    drain();
    mute = 1'b0;

    // Reset mid-ON aborts with no done pulse, then a fresh trigger replays fully
    play(4'd7, 1, CM, 1'b0);
    tick_n(5);
    exp_q.delete();
    rst = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0, 1);
    tick();
    rst = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 3);
    tick_n(3);
    play(4'd7, 1, CM, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
